// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads one 64-bit key and presents the sixteen
// 48-bit round subkeys one per handshake, in encrypt order (K1..K16) or
// decrypt order (K16..K1). Bit numbering is MSB-first: FIPS bit n of the key
// is key_i[64-n], FIPS bit n of the subkey is subkey_o[48-n].
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    output logic [47:0] subkey_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [3:0]  round_o,
    output logic        last_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Permuted Choice 1: FIPS key bit numbers feeding C (0..27) then D (28..55)
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Permuted Choice 2: FIPS bit numbers of the 56-bit {C,D} per subkey bit
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_reg, state_next;
    logic [27:0] c_reg, c_next;
    logic [27:0] d_reg, d_next;
    logic        mode_reg, mode_next;
    logic [3:0]  round_reg, round_next;

    logic [27:0] pc1_c;
    logic [27:0] pc1_d;
    logic [55:0] cd;
    logic [4:0]  shift_idx;
    logic        shift_two;
    logic        unused_parity;

    // True where the FIPS shift schedule S[k] is 2 (S = 1 only at k = 1, 2, 9, 16)
    function automatic logic is_two_shift(input logic [4:0] k);
        case (k)
            5'd1, 5'd2, 5'd9, 5'd16: is_two_shift = 1'b0;
            default:                 is_two_shift = 1'b1;
        endcase
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        rotl = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        rotr = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Parity bits take no part in the schedule
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

    genvar gi;

    // PC-1 is pure wiring from the key port into the two 28-bit halves
    generate
        for (gi = 0; gi < 28; gi++) begin : g_pc1
            assign pc1_c[27-gi] = key_i[64-PC1_TAB[gi]];
            assign pc1_d[27-gi] = key_i[64-PC1_TAB[gi+28]];
        end
    endgenerate

    // PC-2 is pure wiring from the C/D flops to the subkey port
    assign cd = {c_reg, d_reg};
    generate
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign subkey_o[47-gi] = cd[56-PC2_TAB[gi]];
        end
    endgenerate

    // Encrypt moves from K(r+1) to K(r+2) by the left shift S[r+2]; decrypt
    // moves from K(16-r) back to K(15-r) by undoing the left shift S[16-r].
    assign shift_idx = mode_reg ? (5'd16 - {1'b0, round_reg})
                                : ({1'b0, round_reg} + 5'd2);
    assign shift_two = is_two_shift(shift_idx);

    assign key_ready_o    = (state_reg == IDLE);
    assign subkey_valid_o = (state_reg == RUN);
    assign round_o        = round_reg;
    assign last_o         = (state_reg == RUN) && (round_reg == 4'd15);

    // Next-state logic: key load in IDLE, one schedule step per subkey handshake in RUN
    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        mode_next  = mode_reg;
        round_next = round_reg;
        case (state_reg)
            IDLE: begin
                if (key_valid_i) begin
                    state_next = RUN;
                    mode_next  = decrypt_i;
                    round_next = 4'd0;
                    if (decrypt_i) begin
                        // C16/D16 equal C0/D0: total left rotation is 28
                        c_next = pc1_c;
                        d_next = pc1_d;
                    end else begin
                        c_next = rotl(pc1_c, 1'b0);
                        d_next = rotl(pc1_d, 1'b0);
                    end
                end
            end
            RUN: begin
                if (subkey_ready_i) begin
                    if (round_reg == 4'd15) begin
                        state_next = IDLE;
                        round_next = 4'd0;
                        c_next     = 28'd0;
                        d_next     = 28'd0;
                    end else begin
                        round_next = round_reg + 4'd1;
                        if (mode_reg) begin
                            c_next = rotr(c_reg, shift_two);
                            d_next = rotr(d_reg, shift_two);
                        end else begin
                            c_next = rotl(c_reg, shift_two);
                            d_next = rotl(d_reg, shift_two);
                        end
                    end
                end
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            c_reg     <= 28'd0;
            d_reg     <= 28'd0;
            mode_reg  <= 1'b0;
            round_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            mode_reg  <= mode_next;
            round_reg <= round_next;
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: table of known vectors, handshake
// corner cases, reset mid-run and randomized keys against a reference model
// that builds the whole FIPS schedule up front and reverses it for decrypt.
module tb_des_key_schedule;

    logic        clk;
    logic        rst_n;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        key_valid_i;
    logic        key_ready_o;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic        subkey_ready_i;
    logic [3:0]  round_o;
    logic        last_o;

    int checks = 0;
    int errors = 0;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] SPEC_KEY = 64'h133457799BBCDFF1;

    typedef struct packed {
        logic [63:0] key;
        logic        dec;
        logic [47:0] first;
        logic [47:0] last;
    } vec_t;

    vec_t        vecs [6];
    logic [47:0] exp_ks [16];
    logic [47:0] got_ks [16];

    des_key_schedule dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .key_valid_i    (key_valid_i),
        .key_ready_o    (key_ready_o),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .subkey_ready_i (subkey_ready_i),
        .round_o        (round_o),
        .last_o         (last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: compute K1..K16 straight from the FIPS definition, reverse for decrypt
    task automatic model_keys(input logic [63:0] key, input logic dec);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] k;
        logic [47:0] enc [16];
        for (int i = 0; i < 28; i++) begin
            c[27-i] = key[64-PC1[i]];
            d[27-i] = key[64-PC1[i+28]];
        end
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[47-j] = cd[56-PC2[j]];
            enc[r] = k;
        end
        for (int r = 0; r < 16; r++) exp_ks[r] = dec ? enc[15-r] : enc[r];
    endtask

    // Present a key for one edge; optionally keep key_valid_i high with a follow-up key
    task automatic load_key(input logic [63:0] key, input logic dec, input bit hold,
                            input logic [63:0] nkey, input logic ndec);
        check("key_ready_idle", 64'(key_ready_o), 64'd1);
        key_i       = key;
        decrypt_i   = dec;
        key_valid_i = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            key_i     = nkey;
            decrypt_i = ndec;
        end else begin
            key_valid_i = 1'b0;
        end
    endtask

    // Consume all 16 subkeys, checking every presented cycle against the model
    task automatic drain(input logic [63:0] key, input logic dec, input int stall_round,
                         input int stall_n, input int pulse_round, input bit rand_ready,
                         output int vcycles);
        int idx     = 0;
        int stalled = 0;
        int budget  = 200;
        bit pulsed  = 0;
        bit drop_valid;
        model_keys(key, dec);
        vcycles = 0;
        while (idx < 16) begin
            if (budget == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got idx %0d expected 16", idx);
                break;
            end
            budget--;
            check("subkey_valid", 64'(subkey_valid_o), 64'd1);
            if (!subkey_valid_o) break;
            vcycles++;
            check("key_ready_busy", 64'(key_ready_o), 64'd0);
            check("round_o", 64'(round_o), 64'(idx));
            check("subkey_o", 64'(subkey_o), 64'(exp_ks[idx]));
            check("last_o", 64'(last_o), 64'(idx == 15));
            drop_valid = 0;
            if (idx == pulse_round && !pulsed) begin
                key_valid_i = 1'b1;
                key_i       = key ^ 64'hA5A5_5A5A_C3C3_3C3C;
                decrypt_i   = ~dec;
                pulsed      = 1;
                drop_valid  = 1;
            end
            if (idx == stall_round && stalled < stall_n) begin
                subkey_ready_i = 1'b0;
                stalled++;
            end else if (rand_ready && $urandom_range(0, 2) == 0) begin
                subkey_ready_i = 1'b0;
            end else begin
                subkey_ready_i = 1'b1;
                got_ks[idx] = subkey_o;
                idx++;
            end
            @(posedge clk); #1;
            if (drop_valid) key_valid_i = 1'b0;
        end
        subkey_ready_i = 1'b1;
    endtask

    task automatic check_idle_after_run();
        check("ready_after_last", 64'(key_ready_o), 64'd1);
        check("valid_after_last", 64'(subkey_valid_o), 64'd0);
        check("subkey_cleared", 64'(subkey_o), 64'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_key_ready", 64'(key_ready_o), 64'd1);
        check("rst_subkey_valid", 64'(subkey_valid_o), 64'd0);
        check("rst_subkey", 64'(subkey_o), 64'd0);
        check("rst_round", 64'(round_o), 64'd0);
        check("rst_last", 64'(last_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vc;
        int budget;
        logic [63:0] rkey;
        logic        rdec;
        int          srnd;
        int          sn;

        vecs[0] = '{key: SPEC_KEY, dec: 1'b0, first: 48'h1B02EFFC7072, last: 48'hCB3D8B0E17F5};
        vecs[1] = '{key: SPEC_KEY, dec: 1'b1, first: 48'hCB3D8B0E17F5, last: 48'h1B02EFFC7072};
        vecs[2] = '{key: 64'h0101010101010101, dec: 1'b0, first: 48'h0, last: 48'h0};
        vecs[3] = '{key: 64'h0101010101010101, dec: 1'b1, first: 48'h0, last: 48'h0};
        vecs[4] = '{key: 64'hFEFEFEFEFEFEFEFE, dec: 1'b0, first: 48'hFFFFFFFFFFFF, last: 48'hFFFFFFFFFFFF};
        vecs[5] = '{key: 64'h123556789ABDDEF0, dec: 1'b0, first: 48'h1B02EFFC7072, last: 48'hCB3D8B0E17F5};

        rst_n          = 1'b0;
        key_i          = 64'd0;
        decrypt_i      = 1'b0;
        key_valid_i    = 1'b0;
        subkey_ready_i = 1'b1;
        #12;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Known-answer table, loaded back to back from reset release
        for (int v = 0; v < 6; v++) begin
            load_key(vecs[v].key, vecs[v].dec, 1'b0, 64'd0, 1'b0);
            drain(vecs[v].key, vecs[v].dec, -1, 0, -1, 1'b0, vc);
            check("first_subkey", 64'(got_ks[0]), 64'(vecs[v].first));
            check("last_subkey", 64'(got_ks[15]), 64'(vecs[v].last));
            check("valid_cycles", 64'(vc), 64'd16);
            check_idle_after_run();
            $display("vector %0d key %h dec %0d first %h last %h valid %0d",
                     v, vecs[v].key, vecs[v].dec, got_ks[0], got_ks[15], vc);
        end

        // Backpressure: three stalled cycles at round 4
        load_key(SPEC_KEY, 1'b0, 1'b0, 64'd0, 1'b0);
        drain(SPEC_KEY, 1'b0, 4, 3, -1, 1'b0, vc);
        check("stall_valid_cycles", 64'(vc), 64'd19);
        check_idle_after_run();
        $display("backpressure key %h valid %0d", SPEC_KEY, vc);

        // key_valid_i pulse with a different key during RUN is ignored
        load_key(SPEC_KEY, 1'b0, 1'b0, 64'd0, 1'b0);
        drain(SPEC_KEY, 1'b0, -1, 0, 3, 1'b0, vc);
        check("busy_valid_cycles", 64'(vc), 64'd16);
        check_idle_after_run();
        $display("busy pulse key %h valid %0d", SPEC_KEY, vc);

        // key_valid_i held across the end of a run: second key taken right after
        load_key(SPEC_KEY, 1'b0, 1'b1, 64'h0E329232EA6D0D73, 1'b1);
        drain(SPEC_KEY, 1'b0, -1, 0, -1, 1'b0, vc);
        check("held_ready_after_last", 64'(key_ready_o), 64'd1);
        check("held_valid_after_last", 64'(subkey_valid_o), 64'd0);
        @(posedge clk); #1;
        key_valid_i = 1'b0;
        model_keys(64'h0E329232EA6D0D73, 1'b1);
        check("held_second_valid", 64'(subkey_valid_o), 64'd1);
        check("held_second_round", 64'(round_o), 64'd0);
        check("held_second_first", 64'(subkey_o), 64'(exp_ks[0]));
        drain(64'h0E329232EA6D0D73, 1'b1, -1, 0, -1, 1'b0, vc);
        check("held_second_cycles", 64'(vc), 64'd16);
        $display("held valid second key %h dec 1 valid %0d", 64'h0E329232EA6D0D73, vc);

        // Reset pulsed mid-run at round 7
        load_key(SPEC_KEY, 1'b0, 1'b0, 64'd0, 1'b0);
        budget = 40;
        while (round_o != 4'd7 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL reach_round7: got round %0d expected 7", round_o);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_key(SPEC_KEY, 1'b1, 1'b0, 64'd0, 1'b0);
        drain(SPEC_KEY, 1'b1, -1, 0, -1, 1'b0, vc);
        check("post_reset_cycles", 64'(vc), 64'd16);
        check("post_reset_first", 64'(got_ks[0]), 64'h0000CB3D8B0E17F5);
        $display("reset mid-run then key %h dec 1 valid %0d", SPEC_KEY, vc);

        // Randomized keys, modes, stalls and consumer readiness
        for (int n = 0; n < 24; n++) begin
            rkey = {$urandom, $urandom};
            rdec = 1'($urandom_range(0, 1));
            srnd = $urandom_range(0, 15);
            sn   = $urandom_range(0, 3);
            load_key(rkey, rdec, 1'b0, 64'd0, 1'b0);
            drain(rkey, rdec, srnd, sn, -1, 1'b1, vc);
            check_idle_after_run();
            $display("random %0d key %h dec %0d valid %0d", n, rkey, rdec, vc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
